wvb_wr_ctrl_gen2: RTL and testbench

WVB_WR_CTRL_GEN2 -- requirements
Module: wvb_wr_ctrl_gen2

---
 rtl/wvb_wr_ctrl_gen2.sv | 228 ++++++++++++++++++++++
 tb/tb_wvb_wr_ctrl_gen2.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wvb_wr_ctrl_gen2.sv
// -----------------------------------------------------------------------------
// wvb_wr_ctrl_gen2 -- waveform buffer write controller
//
// Waits for an arm pulse, then for a trigger. An accepted trigger opens an
// event that writes pre_config+post_config+1 consecutive samples into the
// circular waveform storage. A one-cycle header write follows, carrying the
// timestamp, start/stop addresses, trigger source and extension flag.
// Triggers that arrive while the storage or the header FIFO is full are
// dropped and counted.
//
// Optional feature macro: WVB_TRIG_EXT_EN
//   defined   : a trig during WRITE extends the event by post_config+1 writes
//               after that cycle, capped at max(N, max_len_config) writes.
//   undefined : trig during WRITE is ignored, every event is N writes,
//               max_len_config is unused.
//
// Ports
//   clk, rst        clock (rising edge), async active-high reset
//   ltc             free-running timestamp, latched at trigger accept
//   pre_config      pretrigger length
//   post_config     posttrigger length
//   max_len_config  max extended event length (extension builds only)
//   trig_mode       1 = re-arm automatically after each header
//   arm             arm pulse, honoured only in IDLE
//   trig, trig_src  trigger and its source tag
//   overflow_in     waveform storage full
//   hdr_full        header FIFO full
//   armed           FSM is in ARMED
//   wvb_wr_addr     storage write address (wraps)
//   wvb_wren        storage write enable
//   eoe             final write of the event
//   hdr_wren        header write strobe
//   hdr_data        {ltc, start_addr, stop_addr, trig_src, ext_flag}
//   overflow_out    one-cycle pulse per dropped trigger
//   drop_cnt        saturating dropped-trigger count
// -----------------------------------------------------------------------------
module wvb_wr_ctrl_gen2 #(
    parameter int P_ADR_WIDTH       = 12,
    parameter int P_LTC_WIDTH       = 48,
    parameter int P_PRE_CONF_WIDTH  = 5,
    parameter int P_POST_CONF_WIDTH = 8,
    parameter int P_MAX_LEN_WIDTH   = 12,
    parameter int P_DROP_CNT_WIDTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [P_LTC_WIDTH-1:0]                 ltc,
    input  logic [P_PRE_CONF_WIDTH-1:0]            pre_config,
    input  logic [P_POST_CONF_WIDTH-1:0]           post_config,
    input  logic [P_MAX_LEN_WIDTH-1:0]             max_len_config,
    input  logic                                   trig_mode,
    input  logic                                   arm,
    input  logic                                   trig,
    input  logic [1:0]                             trig_src,
    input  logic                                   overflow_in,
    input  logic                                   hdr_full,
    output logic                                   armed,
    output logic [P_ADR_WIDTH-1:0]                 wvb_wr_addr,
    output logic                                   wvb_wren,
    output logic                                   eoe,
    output logic                                   hdr_wren,
    output logic [P_LTC_WIDTH+2*P_ADR_WIDTH+2:0]   hdr_data,
    output logic                                   overflow_out,
    output logic [P_DROP_CNT_WIDTH-1:0]            drop_cnt
);

    localparam int HW = P_LTC_WIDTH + 2*P_ADR_WIDTH + 3;
    // N = pre+post+1 needs one bit more than the wider config field
    localparam int NW = ((P_PRE_CONF_WIDTH > P_POST_CONF_WIDTH) ?
                         P_PRE_CONF_WIDTH : P_POST_CONF_WIDTH) + 1;
    // Write counter must hold the length limit plus a full post window
    localparam int CW = ((P_MAX_LEN_WIDTH > NW) ? P_MAX_LEN_WIDTH : NW) + 1;

    localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = 1;
    localparam logic [CW-1:0]          CNT_ONE = 1;
    localparam logic [P_DROP_CNT_WIDTH-1:0] DROP_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WRITE, S_HDR} state_t;

    state_t                       r_state;
    logic                         r_armed;
    logic [P_ADR_WIDTH-1:0]       r_addr;
    logic                         r_wren;
    logic                         r_hdr_wren;
    logic [HW-1:0]                r_hdr_data;
    logic                         r_ovf;
    logic [P_DROP_CNT_WIDTH-1:0]  r_drop_cnt;

    logic [P_ADR_WIDTH-1:0]       r_start;
    logic [P_LTC_WIDTH-1:0]       r_ltc;
    logic [1:0]                   r_src;
    logic [CW-1:0]                r_wcnt;   // 1-based index of the current write
    logic [CW-1:0]                r_end;    // index of the write that ends the event

    logic [CW-1:0]                w_nom_len;
    logic [CW-1:0]                w_new_end;
    logic                         w_ext_hit;
    logic                         w_ext_flag;
    logic                         w_ext_flag_nxt;
    logic                         w_last;

    assign w_nom_len = CW'(pre_config) + CW'(post_config) + CNT_ONE;

`ifdef WVB_TRIG_EXT_EN
    logic [CW-1:0] r_limit;
    logic          r_ext;
    logic [CW-1:0] w_limit;
    logic [CW-1:0] w_ext_end;

    // Length cap is never below the nominal length
    assign w_limit   = (CW'(max_len_config) > w_nom_len) ? CW'(max_len_config) : w_nom_len;
    // A trig on the write at the cap cannot extend; that write is final
    assign w_ext_hit = (r_state == S_WRITE) && trig && (r_wcnt < r_limit);
    assign w_ext_end = r_wcnt + CW'(post_config) + CNT_ONE;

    always_comb begin
        w_new_end = r_end;
        if (w_ext_hit && (w_ext_end > r_end))
            w_new_end = (w_ext_end > r_limit) ? r_limit : w_ext_end;
    end

    assign w_ext_flag = r_ext;
`else
    logic w_unused_max_len;
    assign w_unused_max_len = ^max_len_config;
    assign w_ext_hit        = 1'b0;
    assign w_new_end        = r_end;
    assign w_ext_flag       = 1'b0;
`endif

    assign w_ext_flag_nxt = w_ext_flag | w_ext_hit;
    // Combinational so that a trig on the nominally last write can still
    // withdraw the end-of-event marker in the same cycle.
    assign w_last = (r_state == S_WRITE) && (r_wcnt >= w_new_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_addr     <= '0;
            r_wren     <= 1'b0;
            r_hdr_wren <= 1'b0;
            r_hdr_data <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
            r_start    <= '0;
            r_ltc      <= '0;
            r_src      <= '0;
            r_wcnt     <= '0;
            r_end      <= '0;
`ifdef WVB_TRIG_EXT_EN
            r_limit    <= '0;
            r_ext      <= 1'b0;
`endif
        end else begin
            r_ovf <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (trig) begin
                        if (overflow_in || hdr_full) begin
                            r_ovf <= 1'b1;
                            if (r_drop_cnt != '1)
                                r_drop_cnt <= r_drop_cnt + DROP_ONE;
                        end else begin
                            r_state <= S_WRITE;
                            r_armed <= 1'b0;
                            r_wren  <= 1'b1;
                            r_start <= r_addr;
                            r_ltc   <= ltc;
                            r_src   <= trig_src;
                            r_wcnt  <= CNT_ONE;
                            r_end   <= w_nom_len;
`ifdef WVB_TRIG_EXT_EN
                            r_limit <= w_limit;
                            r_ext   <= 1'b0;
`endif
                        end
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + ADR_ONE;
                    r_wcnt <= r_wcnt + CNT_ONE;
                    r_end  <= w_new_end;
`ifdef WVB_TRIG_EXT_EN
                    if (w_ext_hit)
                        r_ext <= 1'b1;
`endif
                    if (w_last) begin
                        r_state    <= S_HDR;
                        r_wren     <= 1'b0;
                        r_hdr_wren <= 1'b1;
                        r_hdr_data <= {r_ltc, r_start, r_addr, r_src, w_ext_flag_nxt};
                    end
                end
                S_HDR: begin
                    r_hdr_wren <= 1'b0;
                    if (trig_mode) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_armed <= 1'b0;
                    r_wren  <= 1'b0;
                end
            endcase
        end
    end

    assign armed        = r_armed;
    assign wvb_wr_addr  = r_addr;
    assign wvb_wren     = r_wren;
    assign eoe          = w_last;
    assign hdr_wren     = r_hdr_wren;
    assign hdr_data     = r_hdr_data;
    assign overflow_out = r_ovf;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_wvb_wr_ctrl_gen2.sv
// Bench for wvb_wr_ctrl_gen2. Event lengths, addresses and headers come from
// a transaction-level model of the event rules; a second instance with a
// 2-bit drop counter shares the stimulus to observe saturation.
module tb_wvb_wr_ctrl_gen2;
    localparam int ADR = 12;
    localparam int LTC = 48;
    localparam int HW  = LTC + 2*ADR + 3;
`ifdef WVB_TRIG_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic            clk, rst;
    logic [LTC-1:0]  ltc;
    logic [4:0]      pre_config;
    logic [7:0]      post_config;
    logic [11:0]     max_len_config;
    logic            trig_mode, arm, trig, overflow_in, hdr_full;
    logic [1:0]      trig_src;
    logic            armed, wvb_wren, eoe, hdr_wren, overflow_out;
    logic [ADR-1:0]  wvb_wr_addr;
    logic [HW-1:0]   hdr_data;
    logic [15:0]     drop_cnt;
    logic            armed2, wren2, eoe2, hdr_wren2, ovf2;
    logic [ADR-1:0]  addr2;
    logic [HW-1:0]   hdr_data2;
    logic [1:0]      drop_cnt2;

    wvb_wr_ctrl_gen2 u_dut (
        .clk(clk), .rst(rst), .ltc(ltc), .pre_config(pre_config),
        .post_config(post_config), .max_len_config(max_len_config),
        .trig_mode(trig_mode), .arm(arm), .trig(trig), .trig_src(trig_src),
        .overflow_in(overflow_in), .hdr_full(hdr_full), .armed(armed),
        .wvb_wr_addr(wvb_wr_addr), .wvb_wren(wvb_wren), .eoe(eoe),
        .hdr_wren(hdr_wren), .hdr_data(hdr_data), .overflow_out(overflow_out),
        .drop_cnt(drop_cnt));

    wvb_wr_ctrl_gen2 #(.P_DROP_CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .ltc(ltc), .pre_config(pre_config),
        .post_config(post_config), .max_len_config(max_len_config),
        .trig_mode(trig_mode), .arm(arm), .trig(trig), .trig_src(trig_src),
        .overflow_in(overflow_in), .hdr_full(hdr_full), .armed(armed2),
        .wvb_wr_addr(addr2), .wvb_wren(wren2), .eoe(eoe2),
        .hdr_wren(hdr_wren2), .hdr_data(hdr_data2), .overflow_out(ovf2),
        .drop_cnt(drop_cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_addr  = 0;
    int m_drops = 0;
    bit m_armed = 0;
    bit tvec [0:1023];   // trig level on write k (1-based)
    int last_len;
    bit last_ext;
    int last_stop;

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic clear_tvec;
        for (int k = 0; k < 1024; k++) tvec[k] = 1'b0;
    endtask

    // Event length from the rules: N writes nominally; a trig on write k
    // (below the cap) asks for post+1 more writes after k; never beyond cap.
    task automatic model_event(input int pre, input int post, input int maxlen,
                               output int len, output bit ext);
        int cap, want;
        len  = pre + post + 1;
        ext  = 1'b0;
        cap  = (maxlen > len) ? maxlen : len;
        if (EXT) begin
            for (int k = 1; k <= len && k < 1024; k++) begin
                if (tvec[k] && k < cap) begin
                    ext  = 1'b1;
                    want = k + post + 1;
                    if (want > cap) want = cap;
                    if (want > len) len = want;
                end
            end
        end
    endtask

    task automatic run_event(input int pre, input int post, input int maxlen,
                             input bit mode, input bit noisy);
        int            exp_len, nw, bad_addr, bad_eoe, start, stop;
        bit            exp_ext;
        logic [LTC-1:0] l;
        logic [1:0]     s;
        logic [HW-1:0]  exp_hdr;
        pre_config = 5'(pre); post_config = 8'(post);
        max_len_config = 12'(maxlen); trig_mode = mode;
        overflow_in = 0; hdr_full = 0; trig = 0;
        if (!m_armed) begin
            arm = 1; step; arm = 0;
        end
        checks++;
        if (armed !== 1'b1) begin
            errors++; $display("FAIL armed_before_trig: got %b want 1", armed);
        end
        l = {16'($urandom), 32'($urandom)};
        s = 2'($urandom);
        ltc = l; trig_src = s; trig = 1;
        step;
        ltc = {16'($urandom), 32'($urandom)}; trig_src = 2'($urandom);
        model_event(pre, post, maxlen, exp_len, exp_ext);
        start = m_addr;
        nw = 0; bad_addr = 0; bad_eoe = 0;
        while (wvb_wren === 1'b1 && nw < 1100) begin
            nw++;
            trig = (nw < 1024) ? tvec[nw] : 1'b0;
            if (noisy) begin
                overflow_in = 1'($urandom); hdr_full = 1'($urandom); arm = 1'($urandom);
            end
            #1;
            if (wvb_wr_addr !== ADR'(start + nw - 1)) bad_addr++;
            if (eoe !== (nw == exp_len)) bad_eoe++;
            @(posedge clk); #1;
        end
        trig = 0; overflow_in = 0; hdr_full = 0; arm = 1;  // arm ignored in HDR
        stop = (start + exp_len - 1) % 4096;
        exp_hdr = {l, ADR'(start), ADR'(stop), s, exp_ext};
        last_len = nw; last_ext = hdr_data[0]; last_stop = int'(hdr_data[ADR+2:3]);
        checks++;
        if (nw != exp_len) begin
            errors++; $display("FAIL event_len: got %0d want %0d", nw, exp_len);
        end
        checks++;
        if (bad_addr != 0) begin
            errors++; $display("FAIL write_addr: %0d bad addresses, want 0", bad_addr);
        end
        checks++;
        if (bad_eoe != 0) begin
            errors++; $display("FAIL eoe: %0d bad cycles, want 0", bad_eoe);
        end
        checks++;
        if (hdr_wren !== 1'b1 || hdr_data !== exp_hdr) begin
            errors++; $display("FAIL header: wren %b data %h want 1 %h", hdr_wren, hdr_data, exp_hdr);
        end
        step;
        arm = 0;
        checks++;
        if (hdr_wren !== 1'b0 || armed !== mode || hdr_data !== exp_hdr) begin
            errors++; $display("FAIL post_hdr: hdr_wren %b armed %b hold %b want 0 %b 1",
                               hdr_wren, armed, hdr_data === exp_hdr, mode);
        end
        m_addr  = (start + exp_len) % 4096;
        m_armed = mode;
    endtask

    task automatic test_reset;
        rst = 1; ltc = '0; pre_config = '0; post_config = '0; max_len_config = '0;
        trig_mode = 0; arm = 0; trig = 0; trig_src = '0; overflow_in = 0; hdr_full = 0;
        #2;
        checks++;
        if ({armed, wvb_wren, eoe, hdr_wren, overflow_out} !== 5'b0 ||
            wvb_wr_addr !== '0 || hdr_data !== '0 || drop_cnt !== '0 || drop_cnt2 !== '0) begin
            errors++; $display("FAIL reset_state: flags %b addr %h drop %h want all 0",
                               {armed, wvb_wren, eoe, hdr_wren, overflow_out}, wvb_wr_addr, drop_cnt);
        end
        step; rst = 0; step;
        checks++;
        if (armed !== 1'b0 || wvb_wren !== 1'b0) begin
            errors++; $display("FAIL idle_no_arm: armed %b wren %b want 0 0", armed, wvb_wren);
        end
    endtask

    task automatic test_basic;
        clear_tvec();
        run_event(3, 4, 0, 1'b0, 1'b0);
        checks++;
        if (last_len != 8 || last_stop != 7 || last_ext !== 1'b0 || armed !== 1'b0) begin
            errors++; $display("FAIL basic_event: len %0d stop %0d ext %b armed %b want 8 7 0 0",
                               last_len, last_stop, last_ext, armed);
        end
    endtask

    task automatic test_drop;
        int r;
        arm = 1; step; arm = 0; m_armed = 1;
        for (int i = 0; i < 5; i++) begin
            r = $urandom_range(1, 3);
            overflow_in = r[0]; hdr_full = r[1]; trig = 1;
            if (i < 3) begin overflow_in = 0; hdr_full = 1; end
            step;
            trig = 0; overflow_in = 0; hdr_full = 0;
            m_drops++;
            checks++;
            if (overflow_out !== 1'b1 || wvb_wren !== 1'b0 || armed !== 1'b1) begin
                errors++; $display("FAIL drop_pulse: ovf %b wren %b armed %b want 1 0 1",
                                   overflow_out, wvb_wren, armed);
            end
            step;
            checks++;
            if (overflow_out !== 1'b0 || drop_cnt !== 16'(m_drops)) begin
                errors++; $display("FAIL drop_count: ovf %b cnt %0d want 0 %0d", overflow_out, drop_cnt, m_drops);
            end
        end
        checks++;
        if (drop_cnt2 !== 2'd3) begin
            errors++; $display("FAIL drop_saturate: got %0d want 3", drop_cnt2);
        end
    endtask

    task automatic test_random;
        int pre, post, ml;
        for (int e = 0; e < 12; e++) begin
            clear_tvec();
            pre = $urandom_range(0, 7); post = $urandom_range(0, 20); ml = $urandom_range(0, 60);
            for (int k = 1; k < 100; k++) tvec[k] = ($urandom_range(0, 5) == 0);
            run_event(pre, post, ml, 1'($urandom), 1'b1);
        end
    endtask

    task automatic test_wrap;
        int need, len;
        clear_tvec();
        need = (4094 - m_addr + 4096) % 4096;
        while (need > 0) begin
            len = (need > 287) ? 287 : need;
            run_event((len - 1 > 255) ? len - 256 : 0, (len - 1 > 255) ? 255 : len - 1, 0, 1'b1, 1'b0);
            need -= len;
        end
        checks++;
        if (wvb_wr_addr !== 12'hFFE) begin
            errors++; $display("FAIL wrap_setup: addr %h want ffe", wvb_wr_addr);
        end
        run_event(0, 3, 0, 1'b1, 1'b0);
        checks++;
        if (last_len != 4 || last_stop != 1 || armed !== 1'b1) begin
            errors++; $display("FAIL wrap_event: len %0d stop %h armed %b want 4 1 1", last_len, last_stop, armed);
        end
    endtask

    task automatic test_ext;
        clear_tvec();
        tvec[2] = 1'b1;
        run_event(0, 3, 6, 1'b0, 1'b0);
        checks++;
        if (last_len != (EXT ? 6 : 4) || last_ext !== EXT) begin
            errors++; $display("FAIL ext_event: len %0d ext %b want %0d %b", last_len, last_ext, EXT ? 6 : 4, EXT);
        end
        // trig on the nominally final write, then again at the cap
        clear_tvec();
        tvec[4] = 1'b1; tvec[6] = 1'b1;
        run_event(1, 2, 6, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        clear_tvec();
        pre_config = 5'd10; post_config = 8'd10; trig_mode = 1;
        if (!m_armed) begin arm = 1; step; arm = 0; end
        trig = 1; step; trig = 1;
        step; step;
        #3 rst = 1;
        #1;
        checks++;
        if ({armed, wvb_wren, eoe, hdr_wren, overflow_out} !== 5'b0 ||
            wvb_wr_addr !== '0 || hdr_data !== '0 || drop_cnt !== '0) begin
            errors++; $display("FAIL async_reset: flags %b addr %h drop %0d want all 0",
                               {armed, wvb_wren, eoe, hdr_wren, overflow_out}, wvb_wr_addr, drop_cnt);
        end
        #2 rst = 0;
        m_addr = 0; m_drops = 0; m_armed = 0;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (wvb_wren !== 1'b0 || hdr_wren !== 1'b0 || armed !== 1'b0) begin
                errors++; $display("FAIL rearm_needed: wren %b hdr %b armed %b want 0 0 0",
                                   wvb_wren, hdr_wren, armed);
            end
        end
        trig = 0;
        run_event(2, 5, 0, 1'b0, 1'b0);
        checks++;
        if (last_stop != 7) begin
            errors++; $display("FAIL after_reset_event: stop %0d want 7", last_stop);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_random();
        test_ext();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
